// File: rtl/tcm_boot_pkg.sv
// Shared types and defaults for the TCM instruction boot loader.
// Holds the session state enum, the load-beat payload and the window check.
package tcm_boot_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 15;
    localparam int unsigned WE_W   = 4;

    localparam logic [ADDR_W-1:0] TCM_BASE_DEF   = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] TCM_SIZE_DEF   = 32'h0001_0000;
    localparam int unsigned       MAX_WORDS_DEF  = 16384;
    localparam int unsigned       RST_CYCLES_DEF = 4;

    localparam logic [WE_W-1:0] WE_FULL = 4'hf;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERR     = 3'd4
    } boot_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } ld_beat_t;

    // Offset taken in ADDR_W+1 bits so an address below base shows up as a borrow.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        logic [ADDR_W:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return !off[ADDR_W] && (off[ADDR_W-1:0] < size);
    endfunction

endpackage

// File: rtl/tcm_boot_loader_if.sv
// Valid/ready load stream carrying (addr, data, last) beats from the boot source.
interface tcm_boot_loader_if;

    logic                  valid;
    logic                  ready;
    tcm_boot_pkg::ld_beat_t beat;

    modport master (
        output valid,
        output beat,
        input  ready
    );

    modport slave (
        input  valid,
        input  beat,
        output ready
    );

endinterface

// File: rtl/tcm_boot_loader.sv
// Preloads the TCM instruction port from a valid/ready beat stream, then
// holds the core in reset for a fixed count before letting it run.
module tcm_boot_loader
    import tcm_boot_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TCM_BASE   = TCM_BASE_DEF,
    parameter logic [ADDR_W-1:0] TCM_SIZE   = TCM_SIZE_DEF,
    parameter int unsigned       MAX_WORDS  = MAX_WORDS_DEF,
    parameter int unsigned       RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    tcm_boot_loader_if.slave  ld,
    output logic [WE_W-1:0]   tb_inst_we_o,
    output logic [ADDR_W-1:0] tb_inst_addr_o,
    output logic [DATA_W-1:0] tb_inst_data_o,
    output logic              rst_cpu_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  word_cnt_o
);

    localparam int unsigned REL_W = $clog2(RST_CYCLES + 1);

    boot_state_e state_q, state_d;

    logic              beat_ok;
    logic              beat_good;
    logic              sess_clr;
    logic              ready_d, rst_cpu_d, busy_d, done_d, err_d;

    logic [WE_W-1:0]   we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [REL_W-1:0]  rel_q;
    logic              ready_q, rst_cpu_q, busy_q, done_q, err_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_d   = state_q;
        beat_good = 1'b0;
        sess_clr  = 1'b0;
        beat_ok   = (ld.beat.addr[1:0] == 2'b00)
                  && in_window(ld.beat.addr, TCM_BASE, TCM_SIZE)
                  && (cnt_q != CNT_W'(MAX_WORDS));

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    sess_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                // ready_q is high throughout LOAD, so valid alone marks an accept
                if (ld.valid && ready_q) begin
                    if (beat_ok) begin
                        beat_good = 1'b1;
                        if (ld.beat.last) begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RELEASE: begin
                if (rel_q == REL_W'(RST_CYCLES)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d   = (state_d == ST_LOAD);
        rst_cpu_d = (state_d != ST_RUN);
        busy_d    = (state_d == ST_LOAD) || (state_d == ST_RELEASE);
        done_d    = (state_d == ST_RUN);
        err_d     = (state_d == ST_ERR);
    end

    // Write stage, counters and registered status
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            we_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            rel_q     <= '0;
            ready_q   <= 1'b0;
            rst_cpu_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            we_q <= beat_good ? WE_FULL : '0;
            if (beat_good) begin
                addr_q <= ld.beat.addr;
                data_q <= ld.beat.data;
            end

            if (sess_clr) begin
                cnt_q <= '0;
            end else if (beat_good) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Zero on the first RELEASE cycle (the final strobe), then counts the hold cycles
            rel_q <= (state_q == ST_RELEASE) ? rel_q + REL_W'(1) : '0;

            ready_q   <= ready_d;
            rst_cpu_q <= rst_cpu_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ld.ready       = ready_q;
    assign tb_inst_we_o   = we_q;
    assign tb_inst_addr_o = addr_q;
    assign tb_inst_data_o = data_q;
    assign rst_cpu_o      = rst_cpu_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign word_cnt_o     = cnt_q;

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Directed and randomized bench for tcm_boot_loader against a beat-level model.
module tb_tcm_boot_loader;
    import tcm_boot_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SIZE = 32'h0001_0000;
    localparam int          MAXW = 16384;
    localparam int          RSTC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rst_cpu;
    logic        busy;
    logic        done;
    logic        err;
    logic [14:0] cnt;

    tcm_boot_loader_if ld_if ();

    tcm_boot_loader #(
        .TCM_BASE  (BASE),
        .TCM_SIZE  (SIZE),
        .MAX_WORDS (MAXW),
        .RST_CYCLES(RSTC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .ld            (ld_if),
        .tb_inst_we_o  (we),
        .tb_inst_addr_o(waddr),
        .tb_inst_data_o(wdata),
        .rst_cpu_o     (rst_cpu),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .word_cnt_o    (cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_data = 32'h0;
    ld_beat_t    bq[$];
    int          gq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // A beat is written iff word aligned, inside [BASE, BASE+SIZE) and the session is not full
    function automatic bit model_good(input logic [31:0] a, input int n);
        longint la;
        la = longint'(a);
        return ((a % 32'd4) == 32'd0) && (la >= longint'(BASE))
            && (la < longint'(BASE) + longint'(SIZE)) && (n < MAXW);
    endfunction

    task automatic push_beat(input logic [31:0] a, input bit l, input int gap);
        ld_beat_t b;
        b.addr = a;
        b.data = $urandom();
        b.last = l;
        bq.push_back(b);
        gq.push_back(gap);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rst_cpu"}, 32'(rst_cpu), 32'd1);
        chk({tag, "_we"},      32'(we),      32'd0);
        chk({tag, "_ready"},   32'(ld_if.ready), 32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_cnt"},     32'(cnt),     32'd0);
        chk({tag, "_addr"},    waddr,        32'd0);
        chk({tag, "_data"},    wdata,        32'd0);
    endtask

    task automatic start_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_cnt = 0;
        chk("start_ready",   32'(ld_if.ready), 32'd1);
        chk("start_busy",    32'(busy),    32'd1);
        chk("start_err",     32'(err),     32'd0);
        chk("start_done",    32'(done),    32'd0);
        chk("start_rst_cpu", 32'(rst_cpu), 32'd1);
        chk("start_cnt",     32'(cnt),     32'd0);
    endtask

    // Entered on the cycle of the final strobe: core held RSTC more cycles, then runs
    task automatic check_release(input bit poke_start);
        for (int k = 0; k < RSTC; k++) begin
            start = poke_start && (k == 0);
            tick();
            start = 1'b0;
            chk("rel_rst_cpu", 32'(rst_cpu), 32'd1);
            chk("rel_busy",    32'(busy),    32'd1);
            chk("rel_done",    32'(done),    32'd0);
        end
        tick();
        chk("run_rst_cpu", 32'(rst_cpu), 32'd0);
        chk("run_done",    32'(done),    32'd1);
        chk("run_busy",    32'(busy),    32'd0);
        chk("run_ready",   32'(ld_if.ready), 32'd0);
        chk("run_cnt",     32'(cnt),     32'(m_cnt));
    endtask

    // Plays the queued beats; stops at the last good beat, a rejected beat, or queue end
    task automatic run_load(input int start_at, input bit poke_release);
        bit good;
        for (int i = 0; i < bq.size(); i++) begin
            for (int g = 0; g < gq[i]; g++) begin
                ld_if.valid = 1'b0;
                tick();
                chk("gap_we",    32'(we), 32'd0);
                chk("gap_hold",  waddr,   m_addr);
                chk("gap_ready", 32'(ld_if.ready), 32'd1);
            end
            chk("pre_ready", 32'(ld_if.ready), 32'd1);
            ld_if.valid = 1'b1;
            ld_if.beat  = bq[i];
            start       = (i == start_at);
            good        = model_good(bq[i].addr, m_cnt);
            tick();
            ld_if.valid = 1'b0;
            start       = 1'b0;
            if (good) begin
                m_cnt++;
                m_addr = bq[i].addr;
                m_data = bq[i].data;
                chk("wr_we",   32'(we),  32'hf);
                chk("wr_addr", waddr,    m_addr);
                chk("wr_data", wdata,    m_data);
                chk("wr_cnt",  32'(cnt), 32'(m_cnt));
                if (bq[i].last) begin
                    chk("last_ready",   32'(ld_if.ready), 32'd0);
                    chk("last_busy",    32'(busy),    32'd1);
                    chk("last_rst_cpu", 32'(rst_cpu), 32'd1);
                    check_release(poke_release);
                    return;
                end
            end else begin
                chk("bad_we",      32'(we),      32'd0);
                chk("bad_hold",    waddr,        m_addr);
                chk("bad_err",     32'(err),     32'd1);
                chk("bad_rst_cpu", 32'(rst_cpu), 32'd1);
                chk("bad_ready",   32'(ld_if.ready), 32'd0);
                chk("bad_busy",    32'(busy),    32'd0);
                chk("bad_cnt",     32'(cnt),     32'(m_cnt));
                return;
            end
        end
    endtask

    task automatic new_batch();
        bq.delete();
        gq.delete();
    endtask

    initial begin
        int          n;
        int          bad_at;
        logic [31:0] a;

        rst_n       = 1'b0;
        start       = 1'b0;
        ld_if.valid = 1'b0;
        ld_if.beat  = '0;

        // 1: reset values, then idle ignores stray beats
        repeat (5) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(ld_if.ready), 32'd0);
        ld_if.valid     = 1'b1;
        ld_if.beat.addr = 32'h10;
        ld_if.beat.data = 32'hdead_beef;
        ld_if.beat.last = 1'b1;
        tick();
        ld_if.valid = 1'b0;
        chk("idle_we",   32'(we),   32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 2: 30 back-to-back beats, start poked during release
        start_session();
        new_batch();
        for (int i = 0; i < 30; i++) push_beat(32'(i * 4), (i == 29), 0);
        run_load(-1, 1'b1);
        chk("s2_cnt30", 32'(cnt), 32'd30);

        // beats while running are ignored
        ld_if.valid = 1'b1;
        tick();
        tick();
        ld_if.valid = 1'b0;
        chk("runbeat_we",    32'(we),   32'd0);
        chk("runbeat_ready", 32'(ld_if.ready), 32'd0);
        chk("runbeat_done",  32'(done), 32'd1);

        // 3: misaligned beat from a restarted session
        start_session();
        new_batch();
        push_beat(32'h0000_0006, 1'b0, 0);
        run_load(-1, 1'b0);
        start_session();

        // 4: one past the window, then the top word of the window
        new_batch();
        push_beat(32'h0001_0000, 1'b1, 0);
        run_load(-1, 1'b0);
        start_session();
        new_batch();
        push_beat(32'h0000_fffc, 1'b1, 0);
        run_load(-1, 1'b0);

        // 5: valid toggling every cycle, start asserted alongside a beat
        start_session();
        new_batch();
        for (int i = 0; i < 8; i++) push_beat(32'($urandom_range(0, 16383) * 4), (i == 7), (i == 0) ? 0 : 1);
        run_load(3, 1'b0);

        // 6: reset in the middle of a session, then a clean reload
        start_session();
        new_batch();
        for (int i = 0; i < 3; i++) push_beat(32'(i * 4 + 32'h100), 1'b0, 0);
        run_load(-1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        check_reset_vals("midrst_edge");
        rst_n  = 1'b1;
        m_addr = 32'h0;
        m_data = 32'h0;
        tick();
        start_session();
        new_batch();
        for (int i = 0; i < 5; i++) push_beat(32'(i * 4 + 32'h200), (i == 4), 0);
        run_load(-1, 1'b0);

        // 7: random sessions with random gaps and occasional illegal beats
        for (int s = 0; s < 6; s++) begin
            start_session();
            new_batch();
            n      = $urandom_range(4, 12);
            bad_at = $urandom_range(0, 2 * n);
            for (int i = 0; i < n; i++) begin
                a = 32'($urandom_range(0, 16383) * 4);
                if (i == bad_at) begin
                    if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(1, 3));
                    else a = 32'h0001_0000 + ($urandom() & 32'h7fff_ffff);
                end
                push_beat(a, (i == n - 1), $urandom_range(0, 2));
            end
            run_load($urandom_range(0, n - 1), 1'b0);
        end

        // 8: fill the whole window, then one beat too many
        start_session();
        new_batch();
        for (int i = 0; i < MAXW; i++) push_beat(32'(i * 4), 1'b0, 0);
        push_beat(32'h0, 1'b1, 0);
        run_load(-1, 1'b0);
        chk("sat_cnt", 32'(cnt), 32'(MAXW));
        start_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
